// File: rtl/finv_table_loader.sv
// Writer side of the finv reciprocal seed table: packs a byte stream into (a, b) words and writes them.
// Optional trailer checksum enabled by defining FINV_TABLE_LOADER_CHECKSUM_EN.
module finv_table_loader #(
    parameter int ENTRIES = 1024,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              load,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] in_a,
    output logic [DATA_W-1:0] in_b,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NB     = DATA_W / 8;
    localparam int NBYTES = 2 * NB;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

`ifdef FINV_TABLE_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] byte_cnt;
    logic             accept;
    logic             idle_like;

    assign accept    = in_valid && in_ready;
    assign idle_like = (state_q == IDLE) || (state_q == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = RECV;
            end
            RECV: begin
                if (accept && (byte_cnt == LAST_BYTE)) state_d = WRITE;
            end
            WRITE: begin
                if (addr == LAST_ADDR) begin
`ifdef FINV_TABLE_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RECV;
                end
            end
`ifdef FINV_TABLE_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        load     = 1'b0;
        busy     = 1'b0;
        case (state_q)
            RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                load = 1'b1;
                busy = 1'b1;
            end
`ifdef FINV_TABLE_LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Bytes land little-endian: the first NB bytes build in_a, the next NB build in_b.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr     <= '0;
            byte_cnt <= '0;
            in_a     <= '0;
            in_b     <= '0;
            done     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        addr     <= '0;
                        byte_cnt <= '0;
                        done     <= 1'b0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        for (int i = 0; i < NB; i++) begin
                            if (byte_cnt == CNT_W'(i))      in_a[i*8 +: 8] <= in_data;
                            if (byte_cnt == CNT_W'(i + NB)) in_b[i*8 +: 8] <= in_data;
                        end
                        byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (addr != LAST_ADDR) addr <= addr + 1'b1;
`ifndef FINV_TABLE_LOADER_CHECKSUM_EN
                    else done <= 1'b1;
`endif
                end
`ifdef FINV_TABLE_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) done <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef FINV_TABLE_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       err_q;

    // Table bytes plus the trailer must sum to zero modulo 256.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum   <= 8'h00;
            err_q <= 1'b0;
        end else if (idle_like && start) begin
            sum   <= 8'h00;
            err_q <= 1'b0;
        end else if ((state_q == RECV) && accept) begin
            sum <= sum + in_data;
        end else if ((state_q == CHECK) && accept) begin
            err_q <= ((sum + in_data) != 8'h00);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_finv_table_loader.sv
// Directed self-checking bench for finv_table_loader.
// Define FINV_TABLE_LOADER_CHECKSUM_EN to also exercise the trailer checksum.
module tb_finv_table_loader;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 24;
    localparam int ENTRIES = 1024;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              load;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              busy;
    logic              done;
    logic              err;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int last_accept_cyc = 0;
    logic [7:0] byte_sum = 8'h00;

    logic [ADDR_W-1:0] load_addr_q[$];
    logic [DATA_W-1:0] load_a_q[$];
    logic [DATA_W-1:0] load_b_q[$];
    int                load_cyc_q[$];
    logic              load_rdy_q[$];
    logic [DATA_W-1:0] ram_a [ENTRIES];
    logic [DATA_W-1:0] ram_b [ENTRIES];

    finv_table_loader #(
        .ENTRIES(ENTRIES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .load    (load),
        .addr    (addr),
        .in_a    (in_a),
        .in_b    (in_b),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write pulse is logged and mirrored into a shadow of the table RAM.
    always @(negedge clk) begin
        if (load) begin
            load_addr_q.push_back(addr);
            load_a_q.push_back(in_a);
            load_b_q.push_back(in_b);
            load_cyc_q.push_back(cyc);
            load_rdy_q.push_back(in_ready);
            ram_a[addr] <= in_a;
            ram_b[addr] <= in_b;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] allOutputs();
        return {1'b0, in_ready, load, addr, in_a, in_b, busy, done, err};
    endfunction

    function automatic logic [47:0] entryFor(input int i);
        logic [9:0] v;
        v = i[9:0];
        return {8'h5A, 8'h00, ~v[7:0], 8'h00, 6'b0, v[9:8], v[7:0]};
    endfunction

    task automatic clearLog();
        load_addr_q.delete();
        load_a_q.delete();
        load_b_q.delete();
        load_cyc_q.delete();
        load_rdy_q.delete();
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        last_accept_cyc = cyc;
        byte_sum = byte_sum + b;
    endtask

    task automatic applyStimulus(input logic [47:0] entry, input int gap);
        for (int k = 0; k < 6; k++) sendByte(entry[8*k +: 8], gap);
    endtask

    task automatic dropValid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic startSession();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        byte_sum = 8'h00;
    endtask

    task automatic doReset();
        @(negedge clk);
        rstn = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic runSession(input logic [7:0] trailer_delta);
        int errs;
        logic [47:0] e;
        logic [47:0] last_e;
        startSession();
        checkOutput("session_done_cleared", 64'(done), 64'd0);
        clearLog();
        for (int i = 0; i < ENTRIES; i++) begin
            applyStimulus(entryFor(i), 0);
            if (i == 3) begin
                dropValid();
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                checkOutput("start_while_busy", 64'(busy), 64'd1);
            end
        end
`ifdef FINV_TABLE_LOADER_CHECKSUM_EN
        sendByte(8'h00 - byte_sum + trailer_delta, 0);
`endif
        dropValid();
        repeat (3) @(negedge clk);
        checkOutput("session_load_count", 64'(load_addr_q.size()), 64'(ENTRIES));
        errs = 0;
        for (int k = 0; k < load_addr_q.size(); k++) begin
            e = entryFor(k);
            if (load_addr_q[k] != ADDR_W'(k) || load_a_q[k] != e[23:0] || load_b_q[k] != e[47:24]) errs++;
        end
        checkOutput("session_mismatches", 64'(errs), 64'd0);
        checkOutput("session_done", 64'(done), 64'd1);
        checkOutput("session_busy", 64'(busy), 64'd0);
        checkOutput("session_err", 64'(err), (trailer_delta != 8'h00) ? 64'd1 : 64'd0);
        last_e = entryFor(ENTRIES - 1);
        checkOutput("readback_a_3ff", 64'(ram_a[10'h3FF]), 64'h0003FF);
        checkOutput("readback_b_3ff", 64'(ram_b[10'h3FF]), 64'(last_e[47:24]));
    endtask

    initial begin
        logic [47:0] e7;

        #12;
        checkOutput("reset_outputs", allOutputs(), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        clearLog();
        repeat (20) @(negedge clk);
        checkOutput("idle_no_loads", 64'(load_addr_q.size()), 64'd0);
        checkOutput("idle_in_ready", 64'(in_ready), 64'd0);

        // One entry, bytes back-to-back.
        startSession();
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        clearLog();
        applyStimulus(48'h060504030201, 0);
        dropValid();
        repeat (3) @(negedge clk);
        checkOutput("b2b_load_count", 64'(load_addr_q.size()), 64'd1);
        if (load_addr_q.size() == 1) begin
            checkOutput("b2b_addr", 64'(load_addr_q[0]), 64'd0);
            checkOutput("b2b_in_a", 64'(load_a_q[0]), 64'h030201);
            checkOutput("b2b_in_b", 64'(load_b_q[0]), 64'h060504);
            checkOutput("b2b_load_cycle", 64'(load_cyc_q[0]), 64'(last_accept_cyc + 1));
            checkOutput("b2b_ready_in_write", 64'(load_rdy_q[0]), 64'd0);
        end

        // Same entry with a 3-cycle valid gap before every byte.
        doReset();
        startSession();
        clearLog();
        applyStimulus(48'h060504030201, 3);
        dropValid();
        repeat (5) @(negedge clk);
        checkOutput("gap_load_count", 64'(load_addr_q.size()), 64'd1);
        if (load_addr_q.size() == 1) begin
            checkOutput("gap_addr", 64'(load_addr_q[0]), 64'd0);
            checkOutput("gap_in_a", 64'(load_a_q[0]), 64'h030201);
            checkOutput("gap_in_b", 64'(load_b_q[0]), 64'h060504);
            checkOutput("gap_load_cycle", 64'(load_cyc_q[0]), 64'(last_accept_cyc + 1));
        end

        doReset();
        runSession(8'h00);
`ifdef FINV_TABLE_LOADER_CHECKSUM_EN
        runSession(8'h01);
`endif

        // Reset partway through entry 5.
        startSession();
        clearLog();
        for (int i = 0; i < 5; i++) applyStimulus(entryFor(i), 0);
        e7 = entryFor(5);
        for (int k = 0; k < 4; k++) sendByte(e7[8*k +: 8], 0);
        @(negedge clk);
        rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("midreset_outputs", allOutputs(), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("midreset_load_count", 64'(load_addr_q.size()), 64'd5);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        startSession();
        clearLog();
        e7 = entryFor(7);
        applyStimulus(e7, 0);
        dropValid();
        repeat (3) @(negedge clk);
        checkOutput("restart_load_count", 64'(load_addr_q.size()), 64'd1);
        if (load_addr_q.size() == 1) begin
            checkOutput("restart_addr", 64'(load_addr_q[0]), 64'd0);
            checkOutput("restart_in_a", 64'(load_a_q[0]), 64'(e7[23:0]));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
